// File: rtl/hdb3_pkg.sv
// hdb3_pkg
// Shared definitions for the HDB3 line encoder/decoder pair.
//   - Dual-rail symbol encodings {p, n}.
//   - Pulse polarity type and its reset value. The encoder starts from the
//     same polarity, so the first pulse on the line is always positive.
//   - HDB3_MAX_ZEROS: longest legal run of zero symbols on the line.
package hdb3_pkg;

  // {p, n} rail pairs
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b10;
  localparam logic [1:0] SYM_NEG  = 2'b01;
  localparam logic [1:0] SYM_BAD  = 2'b11;

  typedef enum logic {
    POL_NEG = 1'b0,
    POL_POS = 1'b1
  } hdb3_pol_e;

  localparam hdb3_pol_e HDB3_POL_RESET = POL_NEG;

  localparam int HDB3_MAX_ZEROS = 3;

endpackage

// File: rtl/hdb3_err_cnt.sv
// hdb3_err_cnt
// Saturating event counter with synchronous clear.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   inc    in   count one event this cycle
//   clr    in   synchronous clear; wins over a coincident inc
//   count  out  ERR_W-bit count, sticks at all-ones
module hdb3_err_cnt #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [ERR_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ERR_W'(1);
    end
  end

endmodule

// File: rtl/hdb3_dec.sv
// hdb3_dec
// HDB3 line decoder. Takes one dual-rail bipolar symbol per clock, recognises
// bipolar violations, strips B00V / 000V substitutions and recovers NRZ data
// three cycles later. Line-code errors are flagged in the same cycle the
// offending symbol is sampled and counted in a saturating counter.
// Ports:
//   clk        in   clock, one symbol per rising edge
//   rst_n      in   asynchronous active-low reset
//   hdb3_p     in   positive-pulse rail
//   hdb3_n     in   negative-pulse rail
//   err_clr    in   synchronous clear of err_cnt
//   data_out   out  decoded NRZ bit (symbol at edge k appears after edge k+3)
//   out_valid  out  high from the third edge after reset release onwards
//   code_err   out  one-cycle pulse for an erroneous symbol
//   err_cnt    out  saturating count of error cycles
module hdb3_dec
  import hdb3_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hdb3_p,
  input  logic             hdb3_n,
  input  logic             err_clr,
  output logic             data_out,
  output logic             out_valid,
  output logic             code_err,
  output logic [ERR_W-1:0] err_cnt
);

  logic [1:0] sym;
  logic       is_pos;
  logic       is_neg;
  logic       is_bad;
  logic       is_pulse;
  logic       is_v;
  logic       mark;
  logic       v_err;
  logic       run_err;
  logic       err_now;
  hdb3_pol_e  sym_pol;
  hdb3_pol_e  last_pol;

  logic [2:0] sh;
  logic [1:0] raw;
  logic [1:0] zrun;
  logic [1:0] fill;

  assign sym    = {hdb3_p, hdb3_n};
  assign is_pos = (sym == SYM_POS);
  assign is_neg = (sym == SYM_NEG);
  // Both rails high is decoded as a zero symbol and flagged.
  assign is_bad = (sym == SYM_BAD);

  assign is_pulse = is_pos | is_neg;
  assign sym_pol  = is_pos ? POL_POS : POL_NEG;

  // A pulse repeating the previous polarity is a violation.
  assign is_v = is_pulse && (sym_pol == last_pol);
  assign mark = is_pulse && !is_v;

  // A genuine substitution always has two zeros right before its V.
  assign v_err = is_v && (raw != 2'b00);

  // zrun already counts the preceding zeros; one more zero beyond the
  // limit is an error.
  assign run_err = !is_pulse && (zrun == 2'(HDB3_MAX_ZEROS));

  assign err_now = is_bad | v_err | run_err;

  // Decode pipeline. A V wipes the three bits ahead of it: two still in
  // sh[1:0] and the oldest, which would otherwise move to data_out now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= 3'b000;
      raw      <= 2'b00;
      data_out <= 1'b0;
      last_pol <= HDB3_POL_RESET;
    end else begin
      raw <= {raw[0], is_pulse};
      if (is_pulse) begin
        last_pol <= sym_pol;
      end
      if (is_v) begin
        sh       <= 3'b000;
        data_out <= 1'b0;
      end else begin
        sh       <= {sh[1:0], mark};
        data_out <= sh[2];
      end
    end
  end

  // Zero-run counter sticks at its limit so every further zero errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zrun <= 2'd0;
    end else if (is_pulse) begin
      zrun <= 2'd0;
    end else if (zrun != 2'(HDB3_MAX_ZEROS)) begin
      zrun <= zrun + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_err <= 1'b0;
    end else begin
      code_err <= err_now;
    end
  end

  // Fill counter: after three edges the pipeline has been fully loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= 2'd0;
    end else if (fill != 2'd3) begin
      fill <= fill + 2'd1;
    end
  end

  assign out_valid = (fill == 2'd3);

  hdb3_err_cnt #(
    .ERR_W(ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_now),
    .clr   (err_clr),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_hdb3_dec.sv
// tb_hdb3_dec
// Directed bench for hdb3_dec with a narrow (2-bit) error counter so that
// saturation is reachable. Includes a loopback run against a small
// behavioural HDB3 encoder.
module tb_hdb3_dec;
  import hdb3_pkg::*;

  localparam int ERR_W = 2;
  localparam int NBITS = 1000;

  localparam logic [1:0] P = SYM_POS;
  localparam logic [1:0] N = SYM_NEG;
  localparam logic [1:0] Z = SYM_ZERO;
  localparam logic [1:0] X = SYM_BAD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hdb3_p = 1'b0;
  logic             hdb3_n = 1'b0;
  logic             err_clr = 1'b0;
  logic             data_out;
  logic             out_valid;
  logic             code_err;
  logic [ERR_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic       bits [NBITS];
  logic [1:0] enc  [NBITS];

  always #5 clk = ~clk;

  hdb3_dec #(
    .ERR_W(ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hdb3_p    (hdb3_p),
    .hdb3_n    (hdb3_n),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .out_valid (out_valid),
    .code_err  (code_err),
    .err_cnt   (err_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one symbol, let one rising edge take it, sample 1 time unit later.
  task automatic applyStimulus(input logic [1:0] sym, input logic clr);
    hdb3_p  = sym[1];
    hdb3_n  = sym[0];
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string name);
    rst_n   = 1'b0;
    hdb3_p  = 1'b0;
    hdb3_n  = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput({name, ".rst.data"},  32'(data_out),  32'd0);
    checkOutput({name, ".rst.valid"}, 32'(out_valid), 32'd0);
    checkOutput({name, ".rst.err"},   32'(code_err),  32'd0);
    checkOutput({name, ".rst.cnt"},   32'(err_cnt),   32'd0);
    rst_n = 1'b1;
  endtask

  // Symbols are packed first-symbol-leftmost; expected bit vectors read the
  // same way (leftmost = first edge after reset release).
  task automatic runSeq(input string name, input int len, input logic [31:0] syms,
                        input logic [15:0] exp_d, input logic [15:0] exp_e);
    for (int i = 0; i < len; i++) begin
      logic [1:0] s;
      s = syms[2*(len-1-i) +: 2];
      applyStimulus(s, 1'b0);
      checkOutput($sformatf("%s.data[%0d]", name, i),  32'(data_out),  32'(exp_d[len-1-i]));
      checkOutput($sformatf("%s.err[%0d]", name, i),   32'(code_err),  32'(exp_e[len-1-i]));
      checkOutput($sformatf("%s.valid[%0d]", name, i), 32'(out_valid), 32'(i >= 2));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Mark, 000V, mark: bits 1,0,0,0,0,1
    doReset("s1");
    runSeq("s1", 9, 32'({P, Z, Z, Z, P, N, Z, Z, Z}), 16'(9'b000100001), 16'(9'b000000000));

    // B00V: bits 1,1,0,0,0,0; the B must come out as 0
    doReset("s2");
    runSeq("s2", 9, 32'({P, N, P, Z, Z, P, Z, Z, Z}), 16'(9'b000110000), 16'(9'b000000000));

    // Illegal p=n=1 symbol between two marks
    doReset("s3");
    runSeq("s3", 6, 32'({P, X, N, Z, Z, Z}), 16'(6'b000101), 16'(6'b010000));
    checkOutput("s3.cnt", 32'(err_cnt), 32'd1);

    // V after only one zero: flagged, and the two marks before it are wiped
    doReset("s4");
    runSeq("s4", 7, 32'({P, N, Z, N, Z, Z, Z}), 16'(7'b0000000), 16'(7'b0001000));
    checkOutput("s4.cnt", 32'(err_cnt), 32'd1);

    // Five raw zeros after a mark: 4th and 5th zero are errors
    doReset("s5");
    runSeq("s5", 8, 32'({P, Z, Z, Z, Z, Z, N, Z}), 16'(8'b00010000), 16'(8'b00001100));
    checkOutput("s5.cnt", 32'(err_cnt), 32'd2);

    // Saturation, clear-vs-error priority, asynchronous reset mid-stream
    doReset("s6");
    runSeq("s6", 5, 32'({X, X, X, X, X}), 16'(5'b00000), 16'(5'b11111));
    checkOutput("s6.sat", 32'(err_cnt), 32'd3);
    applyStimulus(X, 1'b1);
    checkOutput("s6.clr.err", 32'(code_err), 32'd1);
    checkOutput("s6.clr.cnt", 32'(err_cnt),  32'd0);
    applyStimulus(X, 1'b0);
    checkOutput("s6.after.cnt", 32'(err_cnt), 32'd1);
    applyStimulus(P, 1'b0);
    applyStimulus(N, 1'b0);
    applyStimulus(Z, 1'b0);
    applyStimulus(Z, 1'b0);
    checkOutput("s6.pre.data",  32'(data_out),  32'd1);
    checkOutput("s6.pre.valid", 32'(out_valid), 32'd1);
    checkOutput("s6.pre.cnt",   32'(err_cnt),   32'd1);
    hdb3_p = 1'b0;
    hdb3_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s6.arst.data",  32'(data_out),  32'd0);
    checkOutput("s6.arst.valid", 32'(out_valid), 32'd0);
    checkOutput("s6.arst.err",   32'(code_err),  32'd0);
    checkOutput("s6.arst.cnt",   32'(err_cnt),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(P, 1'b0);
    checkOutput("s6.rel.valid", 32'(out_valid), 32'd0);
    checkOutput("s6.rel.err",   32'(code_err),  32'd0);

    // Loopback against a behavioural HDB3 encoder
    for (int i = 0; i < NBITS; i++) begin
      bits[i] = 1'($urandom_range(0, 1));
      if ((i % 97) < 9) begin
        bits[i] = 1'b0;
      end
    end
    bits[NBITS-1] = 1'b1;
    begin
      logic lp;
      int   odd;
      int   i;
      lp  = 1'b0;
      odd = 0;
      i   = 0;
      while (i < NBITS) begin
        if ((i + 3 < NBITS) && !bits[i] && !bits[i+1] && !bits[i+2] && !bits[i+3]) begin
          if (odd != 0) begin
            enc[i] = Z;
          end else begin
            lp = ~lp;
            enc[i] = lp ? P : N;
          end
          enc[i+1] = Z;
          enc[i+2] = Z;
          enc[i+3] = lp ? P : N;
          odd = 0;
          i += 4;
        end else if (bits[i]) begin
          lp = ~lp;
          enc[i] = lp ? P : N;
          odd ^= 1;
          i++;
        end else begin
          enc[i] = Z;
          i++;
        end
      end
    end
    doReset("lb");
    for (int j = 0; j < NBITS + 3; j++) begin
      applyStimulus((j < NBITS) ? enc[j] : Z, 1'b0);
      checkOutput($sformatf("lb.err[%0d]", j), 32'(code_err), 32'd0);
      if (j >= 3) begin
        checkOutput($sformatf("lb.data[%0d]", j - 3), 32'(data_out), 32'(bits[j-3]));
      end
    end
    checkOutput("lb.cnt", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
